// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for an 8-bit asynchronous SRAM.
// Optional macro SRAM_ARB_RR_EN selects round-robin arbitration (fixed m0 priority otherwise).
module sram_arbiter #(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [7:0]        m0_wdata,
    output logic              m0_ack,
    output logic [7:0]        m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [7:0]        m1_wdata,
    output logic              m1_ack,
    output logic [7:0]        m1_rdata,
    inout  wire  [7:0]        SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_n,
    output logic              SRAM_CE_n,
    output logic              SRAM_OE_n,
    output logic              SRAM_LB_n,
    output logic              SRAM_UB_n
);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              grant_q;
    logic              we_q;
    logic              dq_oe_q;
    logic [7:0]        wdata_q;

    logic              pick_m1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;

`ifdef SRAM_ARB_RR_EN
    logic last_q;  // 1 = m1 was granted last
    assign pick_m1 = m1_req & (~m0_req | ~last_q);
`else
    assign pick_m1 = m1_req & ~m0_req;
`endif

    assign sel_we    = pick_m1 ? m1_we    : m0_we;
    assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;

    // Write data stays on the bus through RECOVER for SRAM hold time.
    assign SRAM_DQ = dq_oe_q ? wdata_q : 8'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            grant_q   <= 1'b0;
            we_q      <= 1'b0;
            dq_oe_q   <= 1'b0;
            wdata_q   <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_n <= 1'b1;
            SRAM_CE_n <= 1'b1;
            SRAM_OE_n <= 1'b1;
            SRAM_LB_n <= 1'b1;
            SRAM_UB_n <= 1'b1;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
`ifdef SRAM_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (m0_req || m1_req) begin
                        grant_q   <= pick_m1;
                        we_q      <= sel_we;
                        wdata_q   <= sel_wdata;
                        SRAM_ADDR <= sel_addr;
                        cnt_q     <= CNT_W'(WAIT_CYCLES - 1);
                        SRAM_CE_n <= 1'b0;
                        SRAM_LB_n <= 1'b0;
                        SRAM_UB_n <= 1'b0;
                        SRAM_OE_n <= sel_we;
                        SRAM_WE_n <= ~sel_we;
                        dq_oe_q   <= sel_we;
                        state_q   <= StAccess;
`ifdef SRAM_ARB_RR_EN
                        last_q    <= pick_m1;
`endif
                    end
                end
                StAccess: begin
                    if (cnt_q == '0) begin
                        SRAM_CE_n <= 1'b1;
                        SRAM_LB_n <= 1'b1;
                        SRAM_UB_n <= 1'b1;
                        SRAM_OE_n <= 1'b1;
                        SRAM_WE_n <= 1'b1;
                        if (!we_q) begin
                            if (grant_q) m1_rdata <= SRAM_DQ;
                            else         m0_rdata <= SRAM_DQ;
                        end
                        m0_ack  <= ~grant_q;
                        m1_ack  <= grant_q;
                        state_q <= StRecover;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StRecover: begin
                    dq_oe_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-timing reference model and an SRAM behavioural model.
module tb_sram_arbiter;
    localparam int AW    = 17;
    localparam int W     = 2;
    localparam int MEMSZ = 1 << AW;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [7:0]    m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m1_ack;
    logic [7:0]    m0_rdata, m1_rdata;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_WE_n, SRAM_CE_n, SRAM_OE_n, SRAM_LB_n, SRAM_UB_n;
    tri1  [7:0]    sram_dq;  // released bus reads back as 8'hFF

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sram_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_n(SRAM_WE_n),
        .SRAM_CE_n(SRAM_CE_n), .SRAM_OE_n(SRAM_OE_n), .SRAM_LB_n(SRAM_LB_n),
        .SRAM_UB_n(SRAM_UB_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model
    logic [7:0] sram_mem [0:MEMSZ-1];
    logic [7:0] ref_mem  [0:MEMSZ-1];
    wire sram_rd = !SRAM_CE_n && !SRAM_OE_n && SRAM_WE_n;
    assign sram_dq = sram_rd ? sram_mem[SRAM_ADDR] : 8'bz;
    always @(negedge clk) if (!SRAM_CE_n && !SRAM_WE_n) sram_mem[SRAM_ADDR] = sram_dq;

    // Reference model: time t since the last grant decides what each cycle must look like.
    int            t = W + 2;
    bit            g_port = 1'b0, g_we = 1'b0, last_m1 = 1'b1;
    logic [AW-1:0] g_addr = '0, exp_addr = '0;
    logic [7:0]    g_wdata = '0, g_rval = '0, exp_dq = 8'hFF, exp_rd0 = '0, exp_rd1 = '0;
    bit            exp_ce = 1'b1, exp_oe = 1'b1, exp_wen = 1'b1, exp_ack0 = 1'b0, exp_ack1 = 1'b0;

    always @(posedge clk) begin
        bit pick, acc, rec;
        if (t == 1 && g_we) ref_mem[g_addr] = g_wdata;
        if (reset) begin
            t = W + 2; exp_rd0 = '0; exp_rd1 = '0; exp_addr = '0; last_m1 = 1'b1;
        end else if (t >= W + 2 && (m0_req || m1_req)) begin
            pick    = m1_req && (!m0_req || (RR && !last_m1));
            g_port  = pick;
            g_we    = pick ? m1_we : m0_we;
            g_addr  = pick ? m1_addr : m0_addr;
            g_wdata = pick ? m1_wdata : m0_wdata;
            g_rval  = ref_mem[g_addr];
            last_m1 = pick;
            exp_addr = g_addr;
            t = 1;
        end else if (t < W + 2) begin
            t++;
        end
        acc = (t >= 1 && t <= W);
        rec = (t == W + 1);
        exp_ce  = !acc;
        exp_oe  = !(acc && !g_we);
        exp_wen = !(acc && g_we);
        if (g_we && (acc || rec)) exp_dq = g_wdata;
        else if (acc)             exp_dq = g_rval;
        else                      exp_dq = 8'hFF;
        exp_ack0 = rec && !g_port;
        exp_ack1 = rec && g_port;
        if (rec && !g_we) begin
            if (g_port) exp_rd1 = g_rval;
            else        exp_rd0 = g_rval;
        end
    end

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 17'h00005;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 17'h00006;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n} !== 5'h1f) begin
                bad++; $display("FAIL reset_strobes got=%b want=11111",
                    {SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n});
            end
            total++;
            if (sram_dq !== 8'hFF) begin bad++; $display("FAIL reset_dq got=%h want=ff", sram_dq); end
            total++;
            if ({m0_ack, m1_ack} !== 2'b00) begin
                bad++; $display("FAIL reset_ack got=%b want=00", {m0_ack, m1_ack});
            end
            total++;
            if ({m0_rdata, m1_rdata} !== 16'h0) begin
                bad++; $display("FAIL reset_rdata got=%h want=0000", {m0_rdata, m1_rdata});
            end
            total++;
            if (SRAM_ADDR !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", SRAM_ADDR); end
        end
        reset = 1'b0;
        tick;
        total++;
        if (SRAM_CE_n !== 1'b0 || SRAM_ADDR !== 17'h00005) begin
            bad++; $display("FAIL reset_first_access got=ce%b/%h want=ce0/00005", SRAM_CE_n, SRAM_ADDR);
        end
        for (int k = 0; k < 10 && !m0_ack; k++) tick;
        total++;
        if (!m0_ack) begin bad++; $display("FAIL reset_m0_ack got=0 want=1"); end
        m0_req = 1'b0; m1_req = 1'b0;
        tick; tick;
    endtask

    task automatic test_read;
        sram_mem[17'h1ABCD] = 8'h5A; ref_mem[17'h1ABCD] = 8'h5A;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 17'h1ABCD;
        for (int k = 1; k <= W + 1; k++) begin
            tick;
            total++;
            if (m1_ack !== 1'b0) begin bad++; $display("FAIL read_m1_ack got=1 want=0"); end
            total++;
            if (k <= W) begin
                if (SRAM_CE_n !== 1'b0 || SRAM_OE_n !== 1'b0 || SRAM_WE_n !== 1'b1 ||
                    SRAM_ADDR !== 17'h1ABCD || m0_ack !== 1'b0) begin
                    bad++; $display("FAIL read_access cyc%0d got=ce%b oe%b we%b a%h ack%b want=ce0 oe0 we1 a1abcd ack0",
                        k, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_ADDR, m0_ack);
                end
            end else begin
                if (m0_ack !== 1'b1 || m0_rdata !== 8'h5A || SRAM_CE_n !== 1'b1 || SRAM_OE_n !== 1'b1) begin
                    bad++; $display("FAIL read_ack got=ack%b d%h ce%b oe%b want=ack1 d5a ce1 oe1",
                        m0_ack, m0_rdata, SRAM_CE_n, SRAM_OE_n);
                end
            end
        end
        m0_req = 1'b0;
        tick;
    endtask

    task automatic test_write;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 17'h00010; m1_wdata = 8'hC3;
        for (int k = 1; k <= W + 2; k++) begin
            tick;
            total++;
            if (k <= W) begin
                if (SRAM_WE_n !== 1'b0 || SRAM_OE_n !== 1'b1 || sram_dq !== 8'hC3) begin
                    bad++; $display("FAIL write_access cyc%0d got=we%b oe%b dq%h want=we0 oe1 dqc3",
                        k, SRAM_WE_n, SRAM_OE_n, sram_dq);
                end
            end else if (k == W + 1) begin
                if (m1_ack !== 1'b1 || SRAM_WE_n !== 1'b1 || sram_dq !== 8'hC3 || m0_ack !== 1'b0) begin
                    bad++; $display("FAIL write_recover got=ack%b we%b dq%h m0ack%b want=ack1 we1 dqc3 m0ack0",
                        m1_ack, SRAM_WE_n, sram_dq, m0_ack);
                end
                m1_req = 1'b0;
            end else begin
                if (sram_dq !== 8'hFF) begin bad++; $display("FAIL write_release got=%h want=ff", sram_dq); end
            end
        end
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 17'h00010;
        for (int k = 0; k < 10 && !m0_ack; k++) tick;
        total++;
        if (m0_ack !== 1'b1 || m0_rdata !== 8'hC3) begin
            bad++; $display("FAIL write_readback got=ack%b d%h want=ack1 dc3", m0_ack, m0_rdata);
        end
        m0_req = 1'b0;
        tick;
    endtask

    task automatic test_priority;
        int n_acks, last_c, c0;
        bit exp_port;
        reset = 1'b1; tick; tick;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 17'h00100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 17'h00200;
        reset = 1'b0;
        n_acks = 0; last_c = 0;
        for (int k = 0; k < 6 * (W + 2) + 10 && n_acks < 6; k++) begin
            tick;
            if (m0_ack || m1_ack) begin
                exp_port = RR ? n_acks[0] : 1'b0;
                total++;
                if ({m1_ack, m0_ack} !== (exp_port ? 2'b10 : 2'b01)) begin
                    bad++; $display("FAIL prio_order #%0d got=%b want=%b", n_acks, {m1_ack, m0_ack},
                        exp_port ? 2'b10 : 2'b01);
                end
                if (n_acks > 0) begin
                    total++;
                    if (cyc - last_c != W + 2) begin
                        bad++; $display("FAIL prio_spacing got=%0d want=%0d", cyc - last_c, W + 2);
                    end
                end
                last_c = cyc;
                n_acks++;
            end
        end
        total++;
        if (n_acks != 6) begin bad++; $display("FAIL prio_count got=%0d want=6", n_acks); end
        m0_req = 1'b0; m1_req = 1'b0;
        tick; tick;
        // m0 wins a simultaneous request, then m1 follows one access slot later
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 10 && !(m0_ack || m1_ack); k++) tick;
        total++;
        if ({m1_ack, m0_ack} !== 2'b01) begin
            bad++; $display("FAIL prio_first got=%b want=01", {m1_ack, m0_ack});
        end
        c0 = cyc;
        m0_req = 1'b0;
        for (int k = 0; k < 10 && !m1_ack; k++) tick;
        total++;
        if (!m1_ack || cyc - c0 != W + 2) begin
            bad++; $display("FAIL prio_m1_gap got=ack%b gap%0d want=ack1 gap%0d", m1_ack, cyc - c0, W + 2);
        end
        m1_req = 1'b0;
        tick; tick;
    endtask

    task automatic test_reset_mid_access;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 17'h00020; m0_wdata = 8'h96;
        tick;
        tick;
        total++;
        if (SRAM_WE_n !== 1'b0) begin bad++; $display("FAIL mid_second_access got=we%b want=we0", SRAM_WE_n); end
        reset = 1'b1;
        tick;
        total++;
        if (SRAM_WE_n !== 1'b1 || SRAM_CE_n !== 1'b1 || sram_dq !== 8'hFF || m0_ack !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=we%b ce%b dq%h ack%b want=we1 ce1 dqff ack0",
                SRAM_WE_n, SRAM_CE_n, sram_dq, m0_ack);
        end
        reset = 1'b0;
        for (int k = 1; k <= W + 1; k++) begin
            tick;
            total++;
            if (m0_ack !== (k == W + 1)) begin
                bad++; $display("FAIL mid_reissue cyc%0d got=ack%b want=ack%b", k, m0_ack, k == W + 1);
            end
        end
        m0_req = 1'b0;
        tick;
        m0_req = 1'b1; m0_we = 1'b0;
        for (int k = 0; k < 10 && !m0_ack; k++) tick;
        total++;
        if (m0_ack !== 1'b1 || m0_rdata !== 8'h96) begin
            bad++; $display("FAIL mid_readback got=ack%b d%h want=ack1 d96", m0_ack, m0_rdata);
        end
        m0_req = 1'b0;
        tick;
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            tick;
            total++;
            if (SRAM_CE_n !== exp_ce || SRAM_LB_n !== exp_ce || SRAM_UB_n !== exp_ce) begin
                bad++; $display("FAIL rnd_ce c%0d got=%b%b%b want=%b", cyc, SRAM_CE_n, SRAM_LB_n, SRAM_UB_n, exp_ce);
            end
            total++;
            if (SRAM_OE_n !== exp_oe || SRAM_WE_n !== exp_wen) begin
                bad++; $display("FAIL rnd_oe_we c%0d got=%b%b want=%b%b", cyc, SRAM_OE_n, SRAM_WE_n, exp_oe, exp_wen);
            end
            total++;
            if (SRAM_ADDR !== exp_addr) begin
                bad++; $display("FAIL rnd_addr c%0d got=%h want=%h", cyc, SRAM_ADDR, exp_addr);
            end
            total++;
            if (sram_dq !== exp_dq) begin
                bad++; $display("FAIL rnd_dq c%0d got=%h want=%h", cyc, sram_dq, exp_dq);
            end
            total++;
            if (m0_ack !== exp_ack0 || m1_ack !== exp_ack1) begin
                bad++; $display("FAIL rnd_ack c%0d got=%b%b want=%b%b", cyc, m0_ack, m1_ack, exp_ack0, exp_ack1);
            end
            total++;
            if (m0_rdata !== exp_rd0 || m1_rdata !== exp_rd1) begin
                bad++; $display("FAIL rnd_rdata c%0d got=%h/%h want=%h/%h", cyc, m0_rdata, m1_rdata,
                    exp_rd0, exp_rd1);
            end
            if (m0_req && m0_ack) m0_req = 1'b0;
            else if (!m0_req && $urandom_range(2) == 0) begin
                m0_req = 1'b1; m0_we = 1'($urandom_range(1));
                m0_addr = AW'($urandom_range(31)); m0_wdata = 8'($urandom_range(255));
            end
            if (m1_req && m1_ack) m1_req = 1'b0;
            else if (!m1_req && $urandom_range(2) == 0) begin
                m1_req = 1'b1; m1_we = 1'($urandom_range(1));
                m1_addr = AW'($urandom_range(31)); m1_wdata = 8'($urandom_range(255));
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (W + 3) tick;
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) begin
            sram_mem[i] = 8'($urandom);
            ref_mem[i]  = sram_mem[i];
        end
        test_reset;
        test_read;
        test_write;
        test_priority;
        test_reset_mid_access;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
